// File: rtl/rtl_settings_pkg.sv
// rtl_settings_pkg: shared width/mode constants, the compare descriptor
// type and small helper functions used by the traffic generator blocks.
//   AMM_DATA_W / DATA_B_W : AMM data bus width in bits / byte lanes
//   ADDR_TYPE             : "BYTE" (partial first/last beats) or "WORD"
//   CMP_ADDR_W            : width of the word address carried to the checker
package rtl_settings_pkg;

    localparam int    AMM_DATA_W  = 32;
    localparam int    DATA_B_W    = AMM_DATA_W / 8;
    localparam int    ADDR_B_W    = 12;
    localparam string ADDR_TYPE   = "BYTE";
    localparam int    AMM_BURST_W = 8;
    localparam int    OFF_W       = $clog2(DATA_B_W);
    // Word address: byte address with the lane offset bits removed.
    localparam int    CMP_ADDR_W  = ADDR_B_W - OFF_W;

    typedef enum logic {
        FIX = 1'b0,
        RND = 1'b1
    } data_mode_t;

    typedef struct packed {
        logic [CMP_ADDR_W-1:0]  start_addr;
        logic [OFF_W-1:0]       start_off;
        logic [OFF_W-1:0]       end_off;
        logic [AMM_BURST_W-2:0] words_count;   // beats - 1
        data_mode_t             data_mode;
        logic [7:0]             data_ptrn;
    } cmp_struct_t;

    // 8-bit Fibonacci LFSR step, feedback from bits 6, 1 and 0.
    function automatic logic [7:0] lfsr8_next(input logic [7:0] b);
        return {b[6:0], b[6] ^ b[1] ^ b[0]};
    endfunction

    // Lane enables for one beat: the first beat starts at start_off, the
    // last beat stops at end_off, a single-beat burst applies both limits.
    function automatic logic [DATA_B_W-1:0] byte_mask(
        input logic             first,
        input logic [OFF_W-1:0] start_off,
        input logic             last,
        input logic [OFF_W-1:0] end_off
    );
        logic [DATA_B_W-1:0] m;
        for (int i = 0; i < DATA_B_W; i++) begin
            m[i] = (!first || (OFF_W'(i) >= start_off)) &&
                   (!last  || (OFF_W'(i) <= end_off));
        end
        return m;
    endfunction

endpackage

// File: rtl/compare_block.sv
// compare_block: checks AMM read-back data of a WRITE_AND_CHECK burst.
// A cmp_en_i pulse loads the burst descriptor; each following read beat is
// compared lane-by-lane (enabled lanes only) against the regenerated
// pattern byte. The first mismatch of a burst pulses cmp_error_o and
// captures address, raw data and expected byte for the CSR block.
//   clk_i, rst_i          : clock, asynchronous active-high reset
//   cmp_en_i/cmp_struct_i : descriptor strobe and payload
//   readdatavalid_i/readdata_i : AMM read beats
//   cmp_busy_o            : check in progress
//   cmp_error_o           : one-cycle first-mismatch pulse
//   err_addr_o/err_data_o/err_ptrn_o : captured details of that mismatch
module compare_block
    import rtl_settings_pkg::*;
#(
    parameter string ADDR_MODE = ADDR_TYPE
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmp_en_i,
    input  cmp_struct_t           cmp_struct_i,
    input  logic                  readdatavalid_i,
    input  logic [AMM_DATA_W-1:0] readdata_i,
    output logic                  cmp_busy_o,
    output logic                  cmp_error_o,
    output logic [CMP_ADDR_W-1:0] err_addr_o,
    output logic [AMM_DATA_W-1:0] err_data_o,
    output logic [7:0]            err_ptrn_o
);

    localparam bit WORD_ADDR = (ADDR_MODE == "WORD");
    localparam int CNT_W     = AMM_BURST_W - 1;

    typedef enum logic {
        IDLE  = 1'b0,
        CHECK = 1'b1
    } state_t;

    state_t              state;
    cmp_struct_t         desc;
    logic [CNT_W-1:0]    beat_cnt;
    logic [7:0]          exp_byte;
    logic                err_seen;

    logic                first_beat;
    logic                last_beat;
    logic [DATA_B_W-1:0] lane_en;
    logic                mismatch;

    assign first_beat = (beat_cnt == '0);
    assign last_beat  = (beat_cnt == desc.words_count);

    always_comb begin
        lane_en  = WORD_ADDR ? '1
                             : byte_mask(first_beat, desc.start_off,
                                         last_beat, desc.end_off);
        mismatch = 1'b0;
        for (int i = 0; i < DATA_B_W; i++) begin
            if (lane_en[i] && (readdata_i[8*i +: 8] != exp_byte))
                mismatch = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            desc        <= '0;
            beat_cnt    <= '0;
            exp_byte    <= '0;
            err_seen    <= 1'b0;
            cmp_busy_o  <= 1'b0;
            cmp_error_o <= 1'b0;
            err_addr_o  <= '0;
            err_data_o  <= '0;
            err_ptrn_o  <= '0;
        end else begin
            cmp_error_o <= 1'b0;
            case (state)
                IDLE: begin
                    // Read beats seen here belong to read-only traffic.
                    if (cmp_en_i) begin
                        desc       <= cmp_struct_i;
                        beat_cnt   <= '0;
                        exp_byte   <= cmp_struct_i.data_ptrn;
                        err_seen   <= 1'b0;
                        state      <= CHECK;
                        cmp_busy_o <= 1'b1;
                    end
                end
                CHECK: begin
                    // cmp_en_i is ignored here; upstream gates on cmp_busy_o.
                    if (readdatavalid_i) begin
                        if (mismatch && !err_seen) begin
                            cmp_error_o <= 1'b1;
                            err_addr_o  <= desc.start_addr + CMP_ADDR_W'(beat_cnt);
                            err_data_o  <= readdata_i;
                            err_ptrn_o  <= exp_byte;
                            err_seen    <= 1'b1;
                        end
                        if (desc.data_mode == RND)
                            exp_byte <= lfsr8_next(exp_byte);
                        if (last_beat) begin
                            state      <= IDLE;
                            cmp_busy_o <= 1'b0;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
